// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM encoding, reset PC default and instruction field positions.
package ifetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_WARM = 2'd1,
        ST_RUN  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          IMEM_AW_DEF  = 14;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int TGT_HI = 25;
    localparam int TGT_LO = 0;
    localparam int TGT_W  = TGT_HI - TGT_LO + 1;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory bus between the fetch stage and a synchronous-read ROM.
// master: drives imem_addr (word address), receives imem_rdata one cycle later.
interface ifetch_unit_if #(
    parameter int AW = 14
) ();

    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;

    modport master (
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        output imem_rdata
    );

endinterface

// File: rtl/ifetch_unit_next_pc_sel.sv
// Combinational next-PC priority mux: jr > j/jal > taken branch > pc+4.
// Ports: pc, jump target field, ALU branch target, rs value, controls -> next_pc, pc_plus4, misaligned.
module ifetch_unit_next_pc_sel
    import ifetch_unit_pkg::*;
(
    input  logic [31:0]      pc,
    input  logic [TGT_W-1:0] target,
    input  logic [31:0]      addr_result,
    input  logic [31:0]      read_data_1,
    input  logic             branch,
    input  logic             nbranch,
    input  logic             jmp,
    input  logic             jal,
    input  logic             jr,
    input  logic             zero,
    output logic [31:0]      next_pc,
    output logic [31:0]      pc_plus4,
    output logic             misaligned
);

    logic take_br;

    assign pc_plus4   = pc + 32'd4;
    assign take_br    = (branch & zero) | (nbranch & ~zero);
    assign misaligned = jr & (|read_data_1[1:0]);

    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = {read_data_1[31:2], 2'b00};
        end else if (jmp | jal) begin
            // Jump region comes from the delay-slot-free pc+4, MIPS style.
            next_pc = {pc_plus4[31:28], target, 2'b00};
        end else if (take_br) begin
            next_pc = addr_result;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC register, ROM address mux, link register and jr fault flag.
// Ports: clock/reset/stall, imem bus, Instruction/instr_valid/pc/branch_base_addr, controls, link_addr, addr_fault.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          IMEM_AW  = IMEM_AW_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         stall,
    ifetch_unit_if.master imem,
    output logic [31:0]  Instruction,
    output logic         instr_valid,
    output logic [31:0]  pc,
    output logic [31:0]  branch_base_addr,
    input  logic [31:0]  Addr_result,
    input  logic [31:0]  Read_data_1,
    input  logic         Branch,
    input  logic         nBranch,
    input  logic         Jmp,
    input  logic         Jal,
    input  logic         Jr,
    input  logic         Zero,
    output logic [31:0]  link_addr,
    output logic         addr_fault
);

    fetch_state_t state;
    fetch_state_t state_nx;

    logic [31:0] next_pc;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic        advance;

    ifetch_unit_next_pc_sel u_next_pc_sel (
        .pc          (pc),
        .target      (Instruction[TGT_HI:TGT_LO]),
        .addr_result (Addr_result),
        .read_data_1 (Read_data_1),
        .branch      (Branch),
        .nbranch     (nBranch),
        .jmp         (Jmp),
        .jal         (Jal),
        .jr          (Jr),
        .zero        (Zero),
        .next_pc     (next_pc),
        .pc_plus4    (pc_plus4),
        .misaligned  (misaligned)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_RST;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_RST:  state_nx = ST_WARM;
            ST_WARM: state_nx = ST_RUN;
            ST_RUN:  state_nx = ST_RUN;
            default: state_nx = ST_RST;
        endcase
    end

    assign advance = (state == ST_RUN) & ~stall;

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc         <= RESET_PC;
            link_addr  <= 32'h0;
            addr_fault <= 1'b0;
        end else if (advance) begin
            pc <= next_pc;
            if (Jal) begin
                link_addr <= pc_plus4;
            end
            if (misaligned) begin
                addr_fault <= 1'b1;
            end
        end
    end

    // Presenting next_pc to the ROM makes its data line up with pc after the edge;
    // re-reading pc while idle keeps Instruction stable.
    assign imem.imem_addr = advance ? next_pc[IMEM_AW+1:2]
                                    : pc[IMEM_AW+1:2];

    assign Instruction      = imem.imem_rdata;
    assign instr_valid      = (state == ST_RUN);
    assign branch_base_addr = pc_plus4;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit with a behavioural PC/link/fault model.
// Directed scenarios followed by randomized control, stall and reset traffic.
module tb_ifetch_unit;

    localparam int          AW    = 14;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] Addr_result = '0;
    logic [31:0] Read_data_1 = '0;
    logic        Branch = 0, nBranch = 0, Jmp = 0, Jal = 0, Jr = 0, Zero = 0;

    logic [31:0] d_instr, d_pc, d_bbase, d_link;
    logic        d_valid, d_fault;

    logic [31:0] rom [0:DEPTH-1];

    int m_phase;
    logic [31:0] m_pc, m_link;
    logic        m_fault;

    int checks = 0;
    int fails  = 0;

    ifetch_unit_if #(.AW(AW)) bus ();

    ifetch_unit #(.RESET_PC(RPC), .IMEM_AW(AW)) dut (
        .clock            (clock),
        .reset            (reset),
        .stall            (stall),
        .imem             (bus),
        .Instruction      (d_instr),
        .instr_valid      (d_valid),
        .pc               (d_pc),
        .branch_base_addr (d_bbase),
        .Addr_result      (Addr_result),
        .Read_data_1      (Read_data_1),
        .Branch           (Branch),
        .nBranch          (nBranch),
        .Jmp              (Jmp),
        .Jal              (Jal),
        .Jr               (Jr),
        .Zero             (Zero),
        .link_addr        (d_link),
        .addr_fault       (d_fault)
    );

    always #5 clock = ~clock;

    always @(posedge clock) bus.imem_rdata <= rom[bus.imem_addr];

    function automatic int widx(logic [31:0] a);
        return int'((a / 32'd4) % DEPTH);
    endfunction

    task automatic clr();
        {Branch, nBranch, Jmp, Jal, Jr, Zero} = '0;
        Addr_result = '0;
        Read_data_1 = '0;
    endtask

    // One clock edge; the model advances from the inputs held across it.
    task automatic step();
        logic [31:0] ins, n_pc, n_link;
        logic        n_fault;
        int          n_ph;
        ins = rom[widx(m_pc)];
        n_pc = m_pc; n_link = m_link; n_fault = m_fault; n_ph = m_phase;
        if (!reset) begin
            n_ph = 0; n_pc = RPC; n_link = 0; n_fault = 0;
        end else if (m_phase == 0) begin
            n_ph = 1;
        end else if (m_phase == 1) begin
            n_ph = 2;
        end else if (!stall) begin
            if (Jr) begin
                n_pc = Read_data_1 - (Read_data_1 % 32'd4);
                if (Read_data_1 % 32'd4 != 0) n_fault = 1;
            end else if (Jmp || Jal) begin
                n_pc = ((m_pc + 32'd4) & 32'hF000_0000)
                     | ((ins % 32'h0400_0000) * 32'd4);
            end else if ((Branch && Zero) || (nBranch && !Zero)) begin
                n_pc = Addr_result;
            end else begin
                n_pc = m_pc + 32'd4;
            end
            if (Jal) n_link = m_pc + 32'd4;
        end
        @(posedge clock);
        #1;
        m_pc = n_pc; m_link = n_link; m_fault = n_fault; m_phase = n_ph;
    endtask

    task automatic go_jr(input logic [31:0] a);
        clr(); Jr = 1; Read_data_1 = a;
        step();
        clr();
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (3) step();
        checks++; if (d_pc !== RPC) begin fails++; $display("FAIL rst_pc got %h exp %h", d_pc, RPC); end
        checks++; if (d_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", d_valid); end
        checks++; if (d_link !== 32'h0) begin fails++; $display("FAIL rst_link got %h exp 0", d_link); end
        checks++; if (d_fault !== 1'b0) begin fails++; $display("FAIL rst_fault got %b exp 0", d_fault); end
        reset = 1;
        step();
        checks++; if (d_valid !== 1'b0) begin fails++; $display("FAIL warm_valid got %b exp 0", d_valid); end
        checks++; if (d_pc !== RPC) begin fails++; $display("FAIL warm_pc got %h exp %h", d_pc, RPC); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step(); else step();
            checks++; if (d_valid !== 1'b1) begin fails++; $display("FAIL run_valid[%0d] got %b exp 1", i, d_valid); end
            checks++; if (d_pc !== 32'(4 * i)) begin fails++; $display("FAIL seq_pc[%0d] got %h exp %h", i, d_pc, 32'(4 * i)); end
            checks++; if (d_instr !== rom[i]) begin fails++; $display("FAIL seq_instr[%0d] got %h exp %h", i, d_instr, rom[i]); end
        end
    endtask

    task automatic test_branch();
        step(); step();
        checks++; if (d_pc !== 32'h10) begin fails++; $display("FAIL pre_br_pc got %h exp 10", d_pc); end
        Branch = 1; Zero = 1; Addr_result = 32'h40;
        step(); clr();
        checks++; if (d_pc !== 32'h40) begin fails++; $display("FAIL beq_pc got %h exp 40", d_pc); end
        checks++; if (d_instr !== rom[16]) begin fails++; $display("FAIL beq_instr got %h exp %h", d_instr, rom[16]); end
        go_jr(32'h10);
        nBranch = 1; Zero = 1; Addr_result = 32'h40;
        step(); clr();
        checks++; if (d_pc !== 32'h14) begin fails++; $display("FAIL bne_pc got %h exp 14", d_pc); end
    endtask

    task automatic test_jal_jr();
        go_jr(32'h8);
        Jal = 1;
        step(); clr();
        checks++; if (d_pc !== 32'h80) begin fails++; $display("FAIL jal_pc got %h exp 80", d_pc); end
        checks++; if (d_link !== 32'hC) begin fails++; $display("FAIL jal_link got %h exp c", d_link); end
        go_jr(32'hC);
        checks++; if (d_pc !== 32'hC) begin fails++; $display("FAIL jr_pc got %h exp c", d_pc); end
        checks++; if (d_fault !== 1'b0) begin fails++; $display("FAIL jr_fault got %b exp 0", d_fault); end
    endtask

    task automatic test_stall();
        logic [31:0] snap;
        go_jr(32'h20);
        snap = d_instr;
        stall = 1; Jmp = 1; Jal = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (d_pc !== 32'h20) begin fails++; $display("FAIL stall_pc[%0d] got %h exp 20", i, d_pc); end
            checks++; if (d_instr !== snap) begin fails++; $display("FAIL stall_instr[%0d] got %h exp %h", i, d_instr, snap); end
            checks++; if (d_link !== 32'hC) begin fails++; $display("FAIL stall_link[%0d] got %h exp c", i, d_link); end
            checks++; if (d_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d] got %b exp 1", i, d_valid); end
        end
        stall = 0; clr();
        step();
        checks++; if (d_pc !== 32'h24) begin fails++; $display("FAIL unstall_pc got %h exp 24", d_pc); end
    endtask

    task automatic test_misaligned();
        go_jr(32'h0000_0103);
        checks++; if (d_pc !== 32'h100) begin fails++; $display("FAIL mis_pc got %h exp 100", d_pc); end
        checks++; if (d_fault !== 1'b1) begin fails++; $display("FAIL mis_fault got %b exp 1", d_fault); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (d_fault !== 1'b1) begin fails++; $display("FAIL fault_sticky[%0d] got %b exp 1", i, d_fault); end
        end
    endtask

    task automatic test_wrap();
        go_jr(32'hFFFF_FFFC);
        checks++; if (d_bbase !== 32'h0) begin fails++; $display("FAIL wrap_bbase got %h exp 0", d_bbase); end
        checks++; if (d_instr !== rom[DEPTH-1]) begin fails++; $display("FAIL alias_instr got %h exp %h", d_instr, rom[DEPTH-1]); end
        step();
        checks++; if (d_pc !== 32'h0) begin fails++; $display("FAIL wrap_pc got %h exp 0", d_pc); end
        checks++; if (d_instr !== rom[0]) begin fails++; $display("FAIL wrap_instr got %h exp %h", d_instr, rom[0]); end
    endtask

    task automatic test_reset_in_stall();
        go_jr(32'h8);
        Jal = 1; step(); clr();
        go_jr(32'h50);
        stall = 1; Jmp = 1;
        step(); step();
        reset = 0;
        step();
        checks++; if (d_pc !== RPC) begin fails++; $display("FAIL rs_pc got %h exp %h", d_pc, RPC); end
        checks++; if (d_link !== 32'h0) begin fails++; $display("FAIL rs_link got %h exp 0", d_link); end
        checks++; if (d_fault !== 1'b0) begin fails++; $display("FAIL rs_fault got %b exp 0", d_fault); end
        checks++; if (d_valid !== 1'b0) begin fails++; $display("FAIL rs_valid got %b exp 0", d_valid); end
        reset = 1; stall = 0; clr();
        step();
        checks++; if (d_valid !== 1'b0) begin fails++; $display("FAIL rewarm_valid got %b exp 0", d_valid); end
        step();
        checks++; if (d_valid !== 1'b1 || d_pc !== RPC) begin fails++; $display("FAIL rerun got v=%b pc=%h exp v=1 pc=%h", d_valid, d_pc, RPC); end
        checks++; if (d_instr !== rom[0]) begin fails++; $display("FAIL rerun_instr got %h exp %h", d_instr, rom[0]); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) != 0);
            stall = ($urandom_range(0, 3) == 0);
            Branch = 1'($urandom); nBranch = 1'($urandom); Zero = 1'($urandom);
            Jmp = ($urandom_range(0, 5) == 0);
            Jal = ($urandom_range(0, 5) == 0);
            Jr  = ($urandom_range(0, 5) == 0);
            Addr_result = $urandom;
            Read_data_1 = $urandom;
            step();
            checks++; if (d_pc !== m_pc) begin fails++; $display("FAIL rnd_pc[%0d] got %h exp %h", i, d_pc, m_pc); end
            checks++; if (d_valid !== (m_phase == 2)) begin fails++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, d_valid, m_phase == 2); end
            checks++; if (d_link !== m_link) begin fails++; $display("FAIL rnd_link[%0d] got %h exp %h", i, d_link, m_link); end
            checks++; if (d_fault !== m_fault) begin fails++; $display("FAIL rnd_fault[%0d] got %b exp %b", i, d_fault, m_fault); end
            checks++; if (d_bbase !== m_pc + 32'd4) begin fails++; $display("FAIL rnd_bbase[%0d] got %h exp %h", i, d_bbase, m_pc + 32'd4); end
            if (m_phase == 2) begin
                checks++;
                if (d_instr !== rom[widx(m_pc)]) begin
                    fails++; $display("FAIL rnd_instr[%0d] got %h exp %h", i, d_instr, rom[widx(m_pc)]);
                end
            end
        end
        reset = 1; stall = 0; clr();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
        rom[2] = {6'b000011, 26'h000_0020};
        m_phase = 0; m_pc = RPC; m_link = 0; m_fault = 0;
        test_reset();
        test_branch();
        test_jal_jr();
        test_stall();
        test_misaligned();
        test_wrap();
        test_reset_in_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
